// File: rtl/datamem_arbiter.sv
// Two-port arbiter and access sequencer for the 256 x 8 datamem array (APB side = port A, I2C side = port B).
// Define DATAMEM_ARB_RR_EN for round-robin tie-breaking; without it port A has fixed priority.
module datamem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              apb_req,
    input  logic              apb_we,
    input  logic [ADDR_W-1:0] apb_addr,
    input  logic [DATA_W-1:0] apb_wdata,
    output logic              apb_gnt,
    output logic              apb_done,
    output logic [DATA_W-1:0] apb_rdata,
    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_gnt,
    output logic              i2c_done,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_b_q, owner_b_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              apb_gnt_q, apb_gnt_d, i2c_gnt_q, i2c_gnt_d;
    logic              apb_done_q, apb_done_d, i2c_done_q, i2c_done_d;
    logic [DATA_W-1:0] apb_rdata_q, apb_rdata_d, i2c_rdata_q, i2c_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_b;
`ifdef DATAMEM_ARB_RR_EN
    logic              last_b_q, last_b_d;
`endif

    // Port B wins only when A is absent or, with round-robin, when A was served last.
    always_comb begin
`ifdef DATAMEM_ARB_RR_EN
        pick_b = i2c_req & (~apb_req | ~last_b_q);
`else
        pick_b = i2c_req & ~apb_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_b_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            apb_gnt_q   <= 1'b0;
            i2c_gnt_q   <= 1'b0;
            apb_done_q  <= 1'b0;
            i2c_done_q  <= 1'b0;
            apb_rdata_q <= '0;
            i2c_rdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef DATAMEM_ARB_RR_EN
            last_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_b_q   <= owner_b_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            apb_gnt_q   <= apb_gnt_d;
            i2c_gnt_q   <= i2c_gnt_d;
            apb_done_q  <= apb_done_d;
            i2c_done_q  <= i2c_done_d;
            apb_rdata_q <= apb_rdata_d;
            i2c_rdata_q <= i2c_rdata_d;
            busy_q      <= busy_d;
`ifdef DATAMEM_ARB_RR_EN
            last_b_q    <= last_b_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (apb_req || i2c_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no branch can infer a latch.
        owner_b_d   = owner_b_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        apb_gnt_d   = 1'b0;
        i2c_gnt_d   = 1'b0;
        apb_done_d  = 1'b0;
        i2c_done_d  = 1'b0;
        apb_rdata_d = apb_rdata_q;
        i2c_rdata_d = i2c_rdata_q;
        busy_d      = (state_d != S_IDLE);
`ifdef DATAMEM_ARB_RR_EN
        last_b_d    = last_b_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (apb_req || i2c_req) begin
                    owner_b_d   = pick_b;
                    we_d        = pick_b ? i2c_we : apb_we;
                    addr_d      = pick_b ? i2c_addr : apb_addr;
                    if (we_d) wdata_d = pick_b ? i2c_wdata : apb_wdata;
                    mem_write_d = we_d;
                    mem_read_d  = ~we_d;
                    apb_gnt_d   = ~pick_b;
                    i2c_gnt_d   = pick_b;
`ifdef DATAMEM_ARB_RR_EN
                    last_b_d    = pick_b;
`endif
                end
            end
            S_ACCESS: begin
                // Read data is captured at the edge that closes ACCESS and shown during RESP.
                apb_done_d = ~owner_b_q;
                i2c_done_d = owner_b_q;
                if (!we_q) begin
                    if (owner_b_q) i2c_rdata_d = mem_read_data;
                    else           apb_rdata_d = mem_read_data;
                end
            end
            default: ;
        endcase
    end

    assign apb_gnt        = apb_gnt_q;
    assign apb_done       = apb_done_q;
    assign apb_rdata      = apb_rdata_q;
    assign i2c_gnt        = i2c_gnt_q;
    assign i2c_done       = i2c_done_q;
    assign i2c_rdata      = i2c_rdata_q;
    assign mem_read_addr  = addr_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: emulates the 256 x 8 array and scores every done
// against a reference model of the memory contents.
module tb_datamem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       apb_req, apb_we, i2c_req, i2c_we;
    logic [7:0] apb_addr, apb_wdata, i2c_addr, i2c_wdata;
    logic       apb_gnt, apb_done, i2c_gnt, i2c_done;
    logic [7:0] apb_rdata, i2c_rdata;
    logic [7:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;
    logic       mem_read, mem_write, busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem_arr [256];
    logic [7:0] mdl [256];
    logic [7:0] apb_q [$];
    logic [7:0] i2c_q [$];
    logic [7:0] exp_apb_rd, exp_i2c_rd;

`ifdef DATAMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    datamem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .apb_req(apb_req), .apb_we(apb_we), .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_gnt(apb_gnt), .apb_done(apb_done), .apb_rdata(apb_rdata),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_gnt(i2c_gnt), .i2c_done(i2c_done), .i2c_rdata(i2c_rdata),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // datamem stand-in: combinational read, write on the rising edge.
    assign mem_read_data = mem_arr[mem_read_addr];
    always @(posedge clk) if (mem_write) mem_arr[mem_write_addr] <= mem_write_data;

    // Scoreboard monitor: strobe exclusivity and read data on every done.
    always @(negedge clk) begin
        logic [7:0] e;
        if (mem_read === 1'b1 || mem_write === 1'b1) begin
            vectors++;
            if ((mem_read && mem_write) || !busy) begin
                miscompares++;
                $display("FAIL strobe_excl: rd=%b wr=%b busy=%b", mem_read, mem_write, busy);
            end
        end
        if (apb_done === 1'b1) begin
            vectors++;
            if (apb_q.size() == 0) begin
                miscompares++;
                $display("FAIL apb_done_unexpected at %0t", $time);
            end else begin
                e = apb_q.pop_front();
                if (apb_rdata !== e) begin
                    miscompares++;
                    $display("FAIL apb_rdata: got %h expected %h", apb_rdata, e);
                end
            end
        end
        if (i2c_done === 1'b1) begin
            vectors++;
            if (i2c_q.size() == 0) begin
                miscompares++;
                $display("FAIL i2c_done_unexpected at %0t", $time);
            end else begin
                e = i2c_q.pop_front();
                if (i2c_rdata !== e) begin
                    miscompares++;
                    $display("FAIL i2c_rdata: got %h expected %h", i2c_rdata, e);
                end
            end
        end
    end

    task automatic sb_push(input bit port_b, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata);
        logic [7:0] e;
        if (we) begin
            mdl[addr] = wdata;
            e = port_b ? exp_i2c_rd : exp_apb_rd;
        end else begin
            e = mdl[addr];
            if (port_b) exp_i2c_rd = e;
            else        exp_apb_rd = e;
        end
        if (port_b) i2c_q.push_back(e);
        else        apb_q.push_back(e);
    endtask

    task automatic drive(input bit port_b, input bit req, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (port_b) begin
            i2c_req = req; i2c_we = we; i2c_addr = addr; i2c_wdata = wdata;
        end else begin
            apb_req = req; apb_we = we; apb_addr = addr; apb_wdata = wdata;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apb_q.delete();
        i2c_q.delete();
        exp_apb_rd = 8'h00;
        exp_i2c_rd = 8'h00;
    endtask

    // One complete access on one port, bounded wait for done.
    task automatic do_op(input bit port_b, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata);
        bit seen = 1'b0;
        sb_push(port_b, we, addr, wdata);
        @(negedge clk);
        drive(port_b, 1'b1, we, addr, wdata);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((port_b ? i2c_done : apb_done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        drive(port_b, 1'b0, we, addr, wdata);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: port_b=%0d addr=%h got no done expected done", port_b, addr);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        vectors++;
        if ({apb_gnt, apb_done, i2c_gnt, i2c_done, mem_read, mem_write, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {apb_gnt, apb_done, i2c_gnt, i2c_done, mem_read, mem_write, busy});
        end
        vectors++;
        if ({mem_read_addr, mem_write_addr, mem_write_data, apb_rdata, i2c_rdata} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0",
                     {mem_read_addr, mem_write_addr, mem_write_data, apb_rdata, i2c_rdata});
        end
        rst = 1'b0;
        apb_q.delete();
        i2c_q.delete();
        exp_apb_rd = 8'h00;
        exp_i2c_rd = 8'h00;
    endtask

    task automatic test_write_read_a();
        sb_push(1'b0, 1'b1, 8'h10, 8'h5A);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A);
        @(negedge clk);  // cycle N+1
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        vectors++;
        if ({apb_gnt, mem_write, mem_read, busy, mem_write_addr, mem_write_data} !== {4'b1101, 8'h10, 8'h5A}) begin
            miscompares++;
            $display("FAIL wr_access: got %b %h %h expected 1101 10 5a",
                     {apb_gnt, mem_write, mem_read, busy}, mem_write_addr, mem_write_data);
        end
        @(negedge clk);  // cycle N+2
        vectors++;
        if ({apb_done, apb_gnt, mem_write} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_done: got %b expected 100", {apb_done, apb_gnt, mem_write});
        end
        @(negedge clk);
        vectors++;
        if ({busy, apb_done, mem_write_addr} !== {2'b00, 8'h10}) begin
            miscompares++;
            $display("FAIL addr_hold: got %b %h expected 00 10", {busy, apb_done}, mem_write_addr);
        end
        do_op(1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        vectors++;
        if (apb_rdata !== 8'h5A) begin
            miscompares++;
            $display("FAIL rdata_held: got %h expected 5a", apb_rdata);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        sb_push(1'b0, 1'b0, 8'h20, 8'h00);
        sb_push(1'b1, 1'b0, 8'hA0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'hA0, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({apb_gnt, apb_done, i2c_gnt, i2c_done} !== {k == 1, k == 2, k == 4, k == 5}) begin
                miscompares++;
                $display("FAIL simul_k%0d: got %b expected %b", k,
                         {apb_gnt, apb_done, i2c_gnt, i2c_done}, {k == 1, k == 2, k == 4, k == 5});
            end
            if (k == 1) apb_req = 1'b0;
            if (k == 4) i2c_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            if (RR && (j % 2 == 1)) sb_push(1'b1, 1'b0, 8'hB0, 8'h00);
            else                    sb_push(1'b0, 1'b0, 8'h30, 8'h00);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'hB0, 8'h00);
        for (int k = 1; k <= 11; k++) begin
            bit ea, eb;
            @(negedge clk);
            ea = (k % 3 == 1) && (!RR || k == 1 || k == 7);
            eb = (k % 3 == 1) && RR && (k == 4 || k == 10);
            vectors++;
            if ({apb_gnt, i2c_gnt} !== {ea, eb}) begin
                miscompares++;
                $display("FAIL held_gnt_k%0d: got %b expected %b", k, {apb_gnt, i2c_gnt}, {ea, eb});
            end
            if (k == 10) begin
                apb_req = 1'b0;
                i2c_req = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (apb_q.size() + i2c_q.size() != 0) begin
            miscompares++;
            $display("FAIL held_pending: got %0d outstanding expected 0", apb_q.size() + i2c_q.size());
        end
    endtask

    task automatic test_drop_mid();
        sb_push(1'b1, 1'b1, 8'hFF, 8'hC3);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hC3);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        vectors++;
        if ({i2c_gnt, mem_write, mem_write_addr, mem_write_data} !== {2'b11, 8'hFF, 8'hC3}) begin
            miscompares++;
            $display("FAIL drop_access: got %b %h %h expected 11 ff c3",
                     {i2c_gnt, mem_write}, mem_write_addr, mem_write_data);
        end
        @(negedge clk);
        vectors++;
        if (i2c_done !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_done: got %b expected 1", i2c_done);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if ({busy, mem_read, mem_write, i2c_gnt} !== 4'b0) begin
                miscompares++;
                $display("FAIL drop_second: got %b expected 0000", {busy, mem_read, mem_write, i2c_gnt});
            end
        end
        do_op(1'b1, 1'b0, 8'hFF, 8'h00);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
        @(negedge clk);  // ACCESS
        vectors++;
        if (mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_access: got mem_read=%b expected 1", mem_read);
        end
        rst = 1'b1;
        apb_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({apb_gnt, apb_done, i2c_gnt, i2c_done, mem_read, mem_write, busy, mem_read_addr, apb_rdata} !== 23'h0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got %b %h %h expected all 0",
                     {apb_gnt, apb_done, i2c_gnt, i2c_done, mem_read, mem_write, busy}, mem_read_addr, apb_rdata);
        end
        rst = 1'b0;
        apb_q.delete();
        i2c_q.delete();
        exp_apb_rd = 8'h00;
        exp_i2c_rd = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if (apb_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_nodone: got %b expected 0", apb_done);
        end
        sb_push(1'b0, 1'b0, 8'h41, 8'h00);
        sb_push(1'b1, 1'b0, 8'hC1, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h41, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'hC1, 8'h00);
        @(negedge clk);
        apb_req = 1'b0;
        vectors++;
        if ({apb_gnt, i2c_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_tie: got %b expected 10", {apb_gnt, i2c_gnt});
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (i2c_gnt === 1'b1) i2c_req = 1'b0;
        end
        i2c_req = 1'b0;
        vectors++;
        if (apb_q.size() + i2c_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_pending: got %0d outstanding expected 0", apb_q.size() + i2c_q.size());
        end
    endtask

    task automatic test_random_mix();
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    do_op(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 8'($urandom));
                end
            end
            begin
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    do_op(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 8'($urandom));
                end
            end
        join
        repeat (3) @(negedge clk);
        vectors++;
        if (apb_q.size() + i2c_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_pending: got %0d outstanding expected 0", apb_q.size() + i2c_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom);
            mdl[i] = mem_arr[i];
        end
        rst = 1'b1;
        exp_apb_rd = 8'h00;
        exp_i2c_rd = 8'h00;
        test_reset();
        test_write_read_a();
        test_simultaneous();
        test_back_to_back();
        test_drop_mid();
        test_reset_mid();
        test_random_mix();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
